// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side request/response bundle of the data-memory access controller.
// master = pipeline (issues requests), slave = dmem_access_ctrl.
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage initiator for a word-wide data memory: byte/half/word loads with extension, sub-word stores
// as read-modify-write. Define MAU_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them.
module dmem_access_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] DataAdr,
    output logic [31:0]       DataIn,
    input  logic [31:0]       DataOut,
    output logic              DMemR,
    output logic              DMemW,
    output logic [1:0]        dbg_state
);
    // Handshake: a request is taken on a rising edge where req_valid & req_ready (ready only in IDLE);
    // resp_valid is a single-cycle pulse and is not back-pressured.
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_word, req_half, req_mis;
    logic [1:0]        req_off;
    logic [3:0]        lane_en;
    logic [31:0]       wrep, merged, shifted, load_ext;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        req_word = bus.req_size[1];
        req_half = (bus.req_size == 2'b01);
`ifdef MAU_MISALIGN_TRAP_EN
        req_mis  = (req_half & bus.req_addr[0]) | (req_word & (|bus.req_addr[1:0]));
        req_off  = bus.req_addr[1:0];
`else
        req_mis  = 1'b0;
        req_off  = req_word ? 2'b00 : (req_half ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0]);
`endif
    end

    // Lane enables and store data replicated into every lane, so the merge is a plain per-byte mux.
    always_comb begin
        lane_en = 4'b1111;
        wrep    = wdata_q;
        case (size_q)
            2'b00: begin
                lane_en = 4'b0001 << off_q;
                wrep    = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en = off_q[1] ? 4'b1100 : 4'b0011;
                wrep    = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        merged = DataOut;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = lane_en[k] ? wrep[8*k +: 8] : DataOut[8*k +: 8];
        end
        shifted = DataOut >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = DataOut;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            adr_q    <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // rdata/err change only on entry to DONE, so they hold between responses.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    off_d    = req_off;
                    adr_d    = bus.req_addr[ADDR_W+1:2];
                    wdata_d  = bus.req_wdata;
                    if (req_mis) begin
                        state_d = S_DONE;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else if (bus.req_we && req_word) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    state_d = S_WRITE;
                    wdata_d = merged;
                end else begin
                    state_d = S_DONE;
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == S_IDLE);
        bus.resp_valid = (state_q == S_DONE);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        DMemR          = (state_q == S_READ);
        DMemW          = (state_q == S_WRITE);
        DataAdr        = adr_q;
        DataIn         = wdata_q;
        dbg_state      = state_q;
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomised bench for dmem_access_ctrl: a byte-lane memory model predicts every response,
// a monitor pops the expected queue on each resp_valid.
module tb_dmem_access_ctrl;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int W      = 37;  // {err, rdata[31:0], reads[1:0], writes[1:0]}
`ifdef MAU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_access_ctrl_if bus();
    logic [ADDR_W-1:0] DataAdr;
    logic [31:0]       DataIn, DataOut;
    logic              DMemR, DMemW;
    logic [1:0]        dbg_state;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .DataAdr(DataAdr), .DataIn(DataIn), .DataOut(DataOut),
        .DMemR(DMemR), .DMemW(DMemW), .dbg_state(dbg_state)
    );

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ref_mem [DEPTH];
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_idx = '0;
    logic [31:0]       load_val = 32'h0;

    assign DataOut = mem[DataAdr];
    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_val;
        else if (DMemW) mem[DataAdr] <= DataIn;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int lat_q[$];
    int wr_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory as bytes-in-words, access aligned down to its size, value shifted out of its lanes.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int nb, off, idx;
        logic [31:0] mask, v;
        nb    = (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
        off   = int'(addr[1:0]);
        idx   = int'(addr[6:2]);
        err   = 1'b0;
        rdata = 32'h0;
        if (TRAP && (off % nb) != 0) begin
            err = 1'b1;
            return;
        end
        off  = (off / nb) * nb;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (we) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        end else begin
            v = (ref_mem[idx] >> (8 * off)) & mask;
            if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            rdata = v;
        end
    endfunction

    task automatic scramble_req();
        bus.req_we     = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int budget;
        logic err;
        logic [31:0] rdata;
        logic [1:0] nrd, nwr;
        int lat;
        budget = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (!bus.req_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
                bus.req_valid = 1'b0;
                return;
            end
        end
        model(we, size, sgn, addr, wdata, err, rdata);
        if (err)          begin lat = 1; nrd = 2'd0; nwr = 2'd0; end
        else if (!we)     begin lat = 2; nrd = 2'd1; nwr = 2'd0; end
        else if (size[1]) begin lat = 2; nrd = 2'd0; nwr = 2'd1; end
        else              begin lat = 3; nrd = 2'd1; nwr = 2'd1; end
        exp_q.push_back({err, rdata, nrd, nwr});
        lat_q.push_back(cyc + lat);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        scramble_req();
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  {31'b0, bus.req_ready},  32'd1);
        chk({tag, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_err"},   {31'b0, bus.resp_err},   32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata,          32'd0);
        chk({tag, "_dmemr"},      {31'b0, DMemR},          32'd0);
        chk({tag, "_dmemw"},      {31'b0, DMemW},          32'd0);
        chk({tag, "_dataadr"},    {27'b0, DataAdr},        32'd0);
        chk({tag, "_datain"},     DataIn,                  32'd0);
    endtask

    // Monitor: strobe accounting per operation, response check, rdata hold between responses.
    initial begin
        int rd, wr, t;
        logic [W-1:0] e;
        logic [31:0] last_rdata;
        rd = 0;
        wr = 0;
        last_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (DMemW) wr_total++;
            if (rst) begin
                rd = 0;
                wr = 0;
                last_rdata = 32'h0;
            end else begin
                if (DMemR) rd++;
                if (DMemW) wr++;
                chk("strobes_exclusive", {31'b0, DMemR & DMemW}, 32'd0);
                if (bus.resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: resp_valid=1 with rdata %h, required no response", bus.resp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        t = lat_q.pop_front();
                        chk("resp_rdata",    bus.resp_rdata,          e[35:4]);
                        chk("resp_err",      {31'b0, bus.resp_err},   {31'b0, e[36]});
                        chk("resp_cycle",    cyc,                     t);
                        chk("read_strobes",  rd,                      {30'b0, e[3:2]});
                        chk("write_strobes", wr,                      {30'b0, e[1:0]});
                        last_rdata = e[35:4];
                    end
                    rd = 0;
                    wr = 0;
                end else begin
                    chk("rdata_hold", bus.resp_rdata, last_rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] snap;
        int wt0;
        bus.req_valid = 1'b0;
        scramble_req();
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_en    = 1'b1;
            load_idx   = ADDR_W'(i);
            load_val   = $urandom;
            ref_mem[i] = load_val;
        end
        @(negedge clk);
        load_en = 1'b0;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Directed cases
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h1122_3344);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0000_0000);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00AA);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0006, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_8001);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_1234);
        issue(1'b0, 2'b11, 1'b1, 32'hFFFF_FF84, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h1234_5677, 32'hFFFF_FF5A);
        drain();

        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Asynchronous reset while a byte store sits in its read phase.
        wt0 = wr_total;
        snap = ref_mem[4];
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0000_0011;
        bus.req_wdata  = 32'h0000_0055;
        chk("rmw_accept_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_read_phase", {31'b0, DMemR}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midcycle_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rmw_no_write", wr_total - wt0, 32'd0);
        chk("rmw_mem_kept", mem[4], snap);
        chk("rmw_idle_ready", {31'b0, bus.req_ready}, 32'd1);

        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0);
        drain();

        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
